bus_arbiter: RTL

- Shares the single system-bus master port between two requesters: M0 (CPU M-stage data port) and M1 (DMA/debug port).
- The shared port is the input side of the system bridge, which decodes DM, TC0 and TC1.
- One single-beat transaction is accepted per cycle, with round-robin arbitration bounded by a burst limit.
- Bus outputs are registered; read data returns to the owning master as a registered response.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/rr_burst_picker.sv | 60 ++++++
 rtl/bus_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system-bus arbiter: address map,
// master index type, response record and the map-check helper.
package bus_pkg;

   localparam logic [31:0] DM_BASE  = 32'h0000_0000;
   localparam logic [31:0] DM_END   = 32'h0000_2FFF;
   localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
   localparam logic [31:0] TC0_END  = 32'h0000_7F0B;
   localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
   localparam logic [31:0] TC1_END  = 32'h0000_7F1B;

   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_e;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   function automatic logic in_range(input logic [63:0] a, input logic [63:0] lo,
                                     input logic [63:0] hi);
      return (a >= lo) && (a <= hi);
   endfunction

   // Addresses are widened to 64 bits so the check works for any ADDR_W up to 64.
   function automatic logic addr_in_map(input logic [63:0] a);
      return in_range(a, 64'(DM_BASE), 64'(DM_END))
          || in_range(a, 64'(TC0_BASE), 64'(TC0_END))
          || in_range(a, 64'(TC1_BASE), 64'(TC1_END));
   endfunction

endpackage

// File: rtl/rr_burst_picker.sv
// Round-robin grant selection between M0 and M1 with a per-owner burst limit;
// purely combinational, the caller owns the last_owner/burst_cnt registers.
module rr_burst_picker
   import bus_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic [1:0]       req_i,
   input  master_e          last_owner_i,
   input  logic [CNT_W-1:0] burst_cnt_i,
   output logic [1:0]       gnt_o,
   output master_e          owner_d_o,
   output logic [CNT_W-1:0] burst_d_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] SAT_CNT = {CNT_W{1'b1}};

   master_e winner_s;

   // Winner selection; a zero count means no burst in progress, so M0 takes the tie.
   always_comb begin
      winner_s = M0;
      case (req_i)
         2'b01:   winner_s = M0;
         2'b10:   winner_s = M1;
         2'b11: begin
            if (burst_cnt_i == {CNT_W{1'b0}}) begin
               winner_s = M0;
            end else if (burst_cnt_i < MAX_CNT) begin
               winner_s = last_owner_i;
            end else begin
               winner_s = (last_owner_i == M0) ? M1 : M0;
            end
         end
         default: winner_s = M0;
      endcase
   end

   // Grant vector and next owner/burst state.
   always_comb begin
      gnt_o     = 2'b00;
      owner_d_o = last_owner_i;
      burst_d_o = {CNT_W{1'b0}};
      if (req_i != 2'b00) begin
         gnt_o     = (winner_s == M1) ? 2'b10 : 2'b01;
         owner_d_o = winner_s;
         if ((winner_s != last_owner_i) || (burst_cnt_i == {CNT_W{1'b0}})) begin
            burst_d_o = CNT_W'(1);
         end else if ((req_i == 2'b11) && (burst_cnt_i != SAT_CNT)) begin
            burst_d_o = burst_cnt_i + CNT_W'(1);
         end else begin
            burst_d_o = burst_cnt_i;
         end
      end else begin
         burst_d_o = {CNT_W{1'b0}};
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system-bus arbiter: one single-beat transaction per cycle, registered
// bus outputs, registered read responses routed back to the owning master.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_byteen,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [31:0]       m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_byteen,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [31:0]       m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_byteen,
   input  logic [31:0]       bus_rdata
);

   logic [1:0]        pick_gnt_s, gnt_s;
   master_e           owner_q, owner_d;
   logic [CNT_W-1:0]  burst_q, burst_d;

   logic [ADDR_W-1:0] sel_addr_s;
   logic [31:0]       sel_wdata_s;
   logic [3:0]        sel_byteen_s;
   master_e           sel_owner_s;
   logic              sel_in_map_s;

   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [3:0]        bus_byteen_q, bus_byteen_d;
   logic              s1_vld_q, s1_vld_d, s1_rd_q, s1_rd_d, s1_err_q, s1_err_d;
   master_e           s1_owner_q, s1_owner_d;
   rsp_t              rsp0_q, rsp0_d, rsp1_q, rsp1_d;

   rr_burst_picker #(.MAX_BURST(MAX_BURST)) u_picker (
      .req_i        ({m1_req, m0_req}),
      .last_owner_i (owner_q),
      .burst_cnt_i  (burst_q),
      .gnt_o        (pick_gnt_s),
      .owner_d_o    (owner_d),
      .burst_d_o    (burst_d)
   );

   // No grant may be issued while reset is asserted.
   always_comb begin
      gnt_s = reset ? pick_gnt_s : 2'b00;
   end

   assign m0_gnt = gnt_s[0];
   assign m1_gnt = gnt_s[1];

   // Mux the granted master's request and check it against the address map.
   always_comb begin
      if (gnt_s[1]) begin
         sel_addr_s   = m1_addr;
         sel_wdata_s  = m1_wdata;
         sel_byteen_s = m1_byteen;
         sel_owner_s  = M1;
      end else begin
         sel_addr_s   = m0_addr;
         sel_wdata_s  = m0_wdata;
         sel_byteen_s = m0_byteen;
         sel_owner_s  = M0;
      end
      sel_in_map_s = addr_in_map(64'(sel_addr_s));
   end

   // Issue stage; out-of-map requests still go out but with byte enables cleared.
   always_comb begin
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_byteen_d = 4'h0;
      s1_vld_d     = 1'b0;
      s1_rd_d      = 1'b0;
      s1_err_d     = 1'b0;
      s1_owner_d   = s1_owner_q;
      if (gnt_s != 2'b00) begin
         bus_addr_d   = sel_addr_s;
         bus_wdata_d  = sel_wdata_s;
         bus_byteen_d = sel_in_map_s ? sel_byteen_s : 4'h0;
         s1_vld_d     = 1'b1;
         s1_rd_d      = (sel_byteen_s == 4'h0);
         s1_err_d     = ~sel_in_map_s;
         s1_owner_d   = sel_owner_s;
      end else begin
         s1_vld_d = 1'b0;
      end
   end

   // Response stage: read data captured from the bridge in the issue cycle.
   always_comb begin
      rsp0_d       = rsp0_q;
      rsp1_d       = rsp1_q;
      rsp0_d.valid = s1_vld_q & s1_rd_q & (s1_owner_q == M0);
      rsp0_d.err   = s1_vld_q & s1_err_q & (s1_owner_q == M0);
      rsp1_d.valid = s1_vld_q & s1_rd_q & (s1_owner_q == M1);
      rsp1_d.err   = s1_vld_q & s1_err_q & (s1_owner_q == M1);
      if (rsp0_d.valid) begin
         rsp0_d.data = bus_rdata;
      end else begin
         rsp0_d.data = rsp0_q.data;
      end
      if (rsp1_d.valid) begin
         rsp1_d.data = bus_rdata;
      end else begin
         rsp1_d.data = rsp1_q.data;
      end
   end

   // All state registers; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner_q      <= M1;
         burst_q      <= {CNT_W{1'b0}};
         bus_addr_q   <= {ADDR_W{1'b0}};
         bus_wdata_q  <= 32'h0;
         bus_byteen_q <= 4'h0;
         s1_vld_q     <= 1'b0;
         s1_rd_q      <= 1'b0;
         s1_err_q     <= 1'b0;
         s1_owner_q   <= M0;
         rsp0_q       <= '{valid: 1'b0, err: 1'b0, data: 32'h0};
         rsp1_q       <= '{valid: 1'b0, err: 1'b0, data: 32'h0};
      end else begin
         owner_q      <= owner_d;
         burst_q      <= burst_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_byteen_q <= bus_byteen_d;
         s1_vld_q     <= s1_vld_d;
         s1_rd_q      <= s1_rd_d;
         s1_err_q     <= s1_err_d;
         s1_owner_q   <= s1_owner_d;
         rsp0_q       <= rsp0_d;
         rsp1_q       <= rsp1_d;
      end
   end

   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_byteen = bus_byteen_q;
   assign m0_rvalid  = rsp0_q.valid;
   assign m0_rdata   = rsp0_q.data;
   assign m0_err     = rsp0_q.err;
   assign m1_rvalid  = rsp1_q.valid;
   assign m1_rdata   = rsp1_q.data;
   assign m1_err     = rsp1_q.err;

endmodule
